// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader for the instruction RAM write port.
// Frame layout: CNT_HI, CNT_LO (big-endian word count N), 4*N payload bytes
// (first byte of each word lands in wd[31:24]), then one checksum byte equal
// to the XOR of every payload byte. Each assembled word is written one cycle
// after its 4th byte is accepted. busy is high while a frame is in flight and
// is meant to hold the core in reset during the load.
module imem_loader #(
  parameter int ADDR_W = 11,   // word-address width of the RAM write port
  parameter int DEPTH  = 1024, // largest accepted word count
  parameter int BASE   = 0     // word address of the first written word
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] wa,
  output logic [31:0]       wd,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state;
  logic [7:0]  cnt_hi;    // high byte of the word count, held until CNT_LO arrives
  logic [15:0] count;     // word count N of the current frame
  logic [15:0] idx;       // index of the next word to be written
  logic [1:0]  byte_cnt;  // position of the next payload byte within its word
  logic [23:0] asm_q;     // first three bytes of the word being assembled
  logic [7:0]  acc;       // running XOR of the payload bytes

  logic        accept;
  logic [15:0] hdr_count;

  // A byte is consumed only when both sides agree; the full count is formed
  // from the latched high byte and the low byte currently on the bus.
  assign accept    = in_valid && in_ready;
  assign hdr_count = {cnt_hi, in_data};

  // Frame-parsing state machine; every output is a register updated here.
  // NOTE: all state in this block uses non-blocking assignments so every
  // register samples the pre-edge value of its neighbours, exactly like flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: wa/wd are cleared here too, so the write port shows a clean
      // all-zero state after reset rather than stale data from an aborted frame.
      state    <= S_IDLE;
      in_ready <= 1'b0;
      we       <= 1'b0;
      wa       <= '0;
      wd       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      cnt_hi   <= '0;
      count    <= '0;
      idx      <= '0;
      byte_cnt <= '0;
      asm_q    <= '0;
      acc      <= '0;
    end else begin
      // The write strobe is a single-cycle pulse unless re-armed below.
      we <= 1'b0;

      case (state)
        // Waiting for a frame, or holding the result of the previous one.
        // A start pulse clears the old result and the per-frame counters.
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state    <= S_HDR_HI;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            idx      <= '0;
            byte_cnt <= '0;
            acc      <= '0;
          end
        end

        S_HDR_HI: begin
          if (accept) begin
            cnt_hi <= in_data;
            state  <= S_HDR_LO;
          end
        end

        // Oversized counts are rejected before any write happens; an empty
        // frame goes straight to the checksum byte (expected value 0).
        S_HDR_LO: begin
          if (accept) begin
            count <= hdr_count;
            if (hdr_count > 16'(DEPTH)) begin
              state    <= S_ERR;
              err      <= 1'b1;
              in_ready <= 1'b0;
              busy     <= 1'b0;
            end else if (hdr_count == 16'd0) begin
              state <= S_CSUM;
            end else begin
              state <= S_DATA;
            end
          end
        end

        // Bytes shift in MSB-first; the 4th byte of a word schedules the
        // write for the next cycle while the stream keeps flowing.
        S_DATA: begin
          if (accept) begin
            acc      <= acc ^ in_data;
            asm_q    <= {asm_q[15:0], in_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              we  <= 1'b1;
              wa  <= ADDR_W'(BASE) + ADDR_W'(idx);
              wd  <= {asm_q, in_data};
              idx <= idx + 16'd1;
              if (idx + 16'd1 == count) begin
                state <= S_CSUM;
              end
            end
          end
        end

        // Final byte decides the outcome; words already written stay written.
        S_CSUM: begin
          if (accept) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            if (in_data == acc) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
        end

        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
          err      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed frames plus random frames, all checked
// against a frame-level reference model that parses the byte list directly.
module tb_imem_loader;

  localparam int ADDR_W = 11;
  localparam int DEPTH  = 1024;
  localparam int BASE   = 0;

  typedef logic [7:0]        byte_q_t [$];
  typedef logic [ADDR_W+31:0] wr_q_t  [$];

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [31:0]       wd;
  logic              busy;
  logic              done;
  logic              err;

  int    total = 0;
  int    bad   = 0;
  bit    mon_en = 1'b0;
  wr_q_t got;

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Capture every write away from the active edge; done/err must never overlap.
  always @(negedge clk) begin
    if (mon_en) begin
      if (we) got.push_back({wa, wd});
      check("done_err_exclusive", {63'd0, done & err}, 64'd0);
    end
  end

  // Reference model: parse the frame as a byte list.
  function automatic void model(input byte_q_t f, output wr_q_t w, output bit e,
                                output int consumed);
    int n;
    logic [7:0]  x;
    logic [31:0] word;
    w = {};
    n = int'({f[0], f[1]});
    if (n > DEPTH) begin
      e = 1'b1;
      consumed = 2;
      return;
    end
    x = 8'h00;
    for (int k = 0; k < n; k++) begin
      word = {f[2+4*k], f[3+4*k], f[4+4*k], f[5+4*k]};
      x = x ^ f[2+4*k] ^ f[3+4*k] ^ f[4+4*k] ^ f[5+4*k];
      w.push_back({ADDR_W'((BASE + k) % (1 << ADDR_W)), word});
    end
    e = (f[2+4*n] != x);
    consumed = 3 + 4*n;
  endfunction

  // Present one byte after a number of idle cycles; returns after it is consumed.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    waited   = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("accept_wait", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
    check({tag, "_we"},       {63'd0, we},       64'd0);
    check({tag, "_wa"},       64'(wa),           64'd0);
    check({tag, "_wd"},       64'(wd),           64'd0);
    check({tag, "_busy"},     {63'd0, busy},     64'd0);
    check({tag, "_done"},     {63'd0, done},     64'd0);
    check({tag, "_err"},      {63'd0, err},      64'd0);
  endtask

  // Run one frame: start, feed the bytes the model says get consumed, compare.
  task automatic run_frame(input string tag, input byte_q_t f, input int gmin,
                           input int gmax, input bit poke_start);
    wr_q_t exp_w;
    bit    exp_e;
    int    consumed;
    int    m;
    model(f, exp_w, exp_e, consumed);
    got = {};
    pulse_start();
    check({tag, "_busy_start"},  {63'd0, busy},     64'd1);
    check({tag, "_ready_start"}, {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < consumed; i++) begin
      if (poke_start && i == 3) pulse_start();
      send_byte(f[i], int'($urandom_range(gmax, gmin)));
    end
    check({tag, "_nwrites"}, 64'(got.size()), 64'(exp_w.size()));
    m = (got.size() < exp_w.size()) ? got.size() : exp_w.size();
    for (int i = 0; i < m; i++) check({tag, "_write"}, 64'(got[i]), 64'(exp_w[i]));
    check({tag, "_done"},  {63'd0, done},     {63'd0, !exp_e});
    check({tag, "_err"},   {63'd0, err},      {63'd0, exp_e});
    check({tag, "_busy"},  {63'd0, busy},     64'd0);
    check({tag, "_ready"}, {63'd0, in_ready}, 64'd0);
  endtask

  initial begin
    byte_q_t f1, f;
    int      n;
    logic [7:0] x, b;

    reset = 1'b1; start = 1'b0; in_data = 8'h00; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;
    check_idle("reset");

    // 1) nominal two-word frame, back-to-back
    f1 = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h54, 8'hDD};
    run_frame("t1", f1, 0, 0, 1'b0);

    // Bytes offered while DONE are not consumed and change nothing.
    got = {};
    in_data = 8'h5A; in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check("done_hold", {63'd0, done}, 64'd1);
    check("done_nowrite", 64'(got.size()), 64'd0);

    // 2) same frame, bad checksum
    f = f1; f[10] = 8'hDC;
    run_frame("t2", f, 0, 0, 1'b0);

    // 3) empty frames
    run_frame("t3a", '{8'h00, 8'h00, 8'h00}, 0, 0, 1'b0);
    run_frame("t3b", '{8'h00, 8'h00, 8'h01}, 0, 0, 1'b0);

    // 4) count above DEPTH, and exactly DEPTH
    run_frame("t4", '{8'h04, 8'h01, 8'h00, 8'h00}, 0, 0, 1'b0);
    f = '{8'h04, 8'h00};
    x = 8'h00;
    for (int i = 0; i < 4*DEPTH; i++) begin
      b = 8'($urandom);
      x ^= b;
      f.push_back(b);
    end
    f.push_back(x);
    run_frame("t4_full", f, 0, 0, 1'b0);

    // 5) three idle cycles between every byte, with a start ignored mid-frame
    run_frame("t5", f1, 3, 3, 1'b1);

    // 6) reset after 6 payload bytes: only word 0 written, outputs cleared
    got = {};
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(f1[i], 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle("t6_reset");
    check("t6_nwrites", 64'(got.size()), 64'd1);
    check("t6_word0", 64'(got[0]), 64'({ADDR_W'(BASE), 32'h20080005}));

    // Reset in the same cycle as the 4th byte of word 1: that write is dropped.
    got = {};
    pulse_start();
    for (int i = 0; i < 9; i++) send_byte(f1[i], 0);
    in_data = f1[9]; in_valid = 1'b1; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    check_idle("t6_pending");
    @(negedge clk);
    check("t6_pending_nwrites", 64'(got.size()), 64'd1);
    run_frame("t6_restart", f1, 0, 0, 1'b0);

    // Random frames: random length, payload, gaps and checksum corruption.
    for (int r = 0; r < 10; r++) begin
      n = int'($urandom_range(6, 0));
      f = '{8'(n >> 8), 8'(n)};
      x = 8'h00;
      for (int i = 0; i < 4*n; i++) begin
        b = 8'($urandom);
        x ^= b;
        f.push_back(b);
      end
      if ($urandom_range(3, 0) == 0) x ^= 8'($urandom_range(255, 1));
      f.push_back(x);
      run_frame("rand", f, 0, 2, 1'($urandom_range(1, 0)));
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
